// File: rtl/pulpino_spi_boot_loader.sv
// Boot sequencer: copies a ROM image into PULPino memory over the SPI-slave
// write command, one 72-bit frame per word, then raises fetch enable.
module pulpino_spi_boot_loader #(
    parameter int unsigned NUM_WORDS = 1024,
    parameter int unsigned ROM_AW    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned CLK_DIV   = 4,   // >= 1
    parameter int unsigned CS_GAP    = 4,   // >= 1
    parameter logic [7:0]  CMD_WRITE = 8'h02
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              rom_req_o,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic              rom_valid_i,
    input  logic [31:0]       rom_rdata_i,
    output logic              spi_clk_o,
    output logic              spi_cs_o,
    output logic              spi_sdo_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              fetch_enable_o,
    output logic [31:0]       word_cnt_o
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       index_q, index_d;
    logic [71:0]       frame_q, frame_d;
    logic [6:0]        bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              rom_req_q, rom_req_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              spi_clk_q, spi_clk_d;
    logic              spi_cs_q, spi_cs_d;
    logic              spi_sdo_q, spi_sdo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fetch_en_q, fetch_en_d;
    logic [31:0]       word_cnt_q, word_cnt_d;
    logic [31:0]       index_nxt;

    // SoC byte address of a word; 32-bit arithmetic wraps naturally.
    function automatic logic [31:0] word_addr(input logic [31:0] idx);
        return BASE_ADDR + {idx[29:0], 2'b00};
    endfunction

    // Next-state and output computation for the load sequencer.
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        frame_d    = frame_q;
        bit_cnt_d  = bit_cnt_q;
        div_d      = div_q;
        gap_d      = gap_q;
        rom_req_d  = rom_req_q;
        rom_addr_d = rom_addr_q;
        spi_clk_d  = spi_clk_q;
        spi_cs_d   = spi_cs_q;
        spi_sdo_d  = spi_sdo_q;
        busy_d     = busy_q;
        done_d     = done_q;
        fetch_en_d = fetch_en_q;
        word_cnt_d = word_cnt_q;
        index_nxt  = index_q + 32'd1;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (NUM_WORDS == 0) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        fetch_en_d = 1'b1;
                    end else begin
                        state_d    = S_FETCH;
                        busy_d     = 1'b1;
                        index_d    = '0;
                        rom_req_d  = 1'b1;
                        rom_addr_d = '0;
                    end
                end
            end
            S_FETCH: begin
                if (rom_valid_i) begin
                    // CS and the first (MSB) bit go out as LOAD begins.
                    frame_d   = {CMD_WRITE, word_addr(index_q), rom_rdata_i};
                    rom_req_d = 1'b0;
                    state_d   = S_LOAD;
                    spi_cs_d  = 1'b0;
                    spi_sdo_d = CMD_WRITE[7];
                    bit_cnt_d = 7'd71;
                    div_d     = '0;
                end
            end
            S_LOAD: begin
                state_d = S_SHIFT;
                div_d   = '0;
            end
            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!spi_clk_q) begin
                        spi_clk_d = 1'b1;
                    end else begin
                        spi_clk_d = 1'b0;
                        if (bit_cnt_q != 7'd0) begin
                            // Data only moves on the falling edge, MSB first.
                            bit_cnt_d = bit_cnt_q - 7'd1;
                            frame_d   = {frame_q[70:0], 1'b0};
                            spi_sdo_d = frame_q[70];
                        end else begin
                            state_d    = S_GAP;
                            spi_cs_d   = 1'b1;
                            spi_sdo_d  = 1'b0;
                            gap_d      = '0;
                            word_cnt_d = word_cnt_q + 32'd1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (index_nxt == NUM_WORDS) begin
                        state_d    = S_DONE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        fetch_en_d = 1'b1;
                    end else begin
                        state_d    = S_FETCH;
                        index_d    = index_nxt;
                        rom_req_d  = 1'b1;
                        rom_addr_d = index_nxt[ROM_AW-1:0];
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers; reset forces the bus idle immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            index_q    <= '0;
            bit_cnt_q  <= '0;
            div_q      <= '0;
            gap_q      <= '0;
            rom_req_q  <= 1'b0;
            rom_addr_q <= '0;
            spi_clk_q  <= 1'b0;
            spi_cs_q   <= 1'b1;
            spi_sdo_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fetch_en_q <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            bit_cnt_q  <= bit_cnt_d;
            div_q      <= div_d;
            gap_q      <= gap_d;
            rom_req_q  <= rom_req_d;
            rom_addr_q <= rom_addr_d;
            spi_clk_q  <= spi_clk_d;
            spi_cs_q   <= spi_cs_d;
            spi_sdo_q  <= spi_sdo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fetch_en_q <= fetch_en_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Frame shift register is pure data and is always reloaded before use.
    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

    assign rom_req_o      = rom_req_q;
    assign rom_addr_o     = rom_addr_q;
    assign spi_clk_o      = spi_clk_q;
    assign spi_cs_o       = spi_cs_q;
    assign spi_sdo_o      = spi_sdo_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign fetch_enable_o = fetch_en_q;
    assign word_cnt_o     = word_cnt_q;

endmodule

// File: tb/tb_pulpino_spi_boot_loader.sv
// Bench for pulpino_spi_boot_loader: three instances (2-word zero-wait ROM,
// 8-word random-latency ROM at a wrapping base address, and 0 words).
module tb_pulpino_spi_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- DUT A: 2 words, CLK_DIV=2, zero-wait ROM
    logic        rst_a, start_a, req_a, valid_a, sck_a, cs_a, sdo_a, busy_a, done_a, fe_a;
    logic [9:0]  addr_a;
    logic [31:0] rdata_a, wcnt_a;
    assign valid_a = req_a;
    assign rdata_a = addr_a[0] ? 32'h12345678 : 32'hDEADBEEF;

    pulpino_spi_boot_loader #(.NUM_WORDS(2), .ROM_AW(10), .BASE_ADDR(32'h0), .CLK_DIV(2),
                              .CS_GAP(4), .CMD_WRITE(8'h02)) dut_a (
        .clk(clk), .rst(rst_a), .start_i(start_a), .rom_req_o(req_a), .rom_addr_o(addr_a),
        .rom_valid_i(valid_a), .rom_rdata_i(rdata_a), .spi_clk_o(sck_a), .spi_cs_o(cs_a),
        .spi_sdo_o(sdo_a), .busy_o(busy_a), .done_o(done_a), .fetch_enable_o(fe_a),
        .word_cnt_o(wcnt_a));

    // ---------------- DUT B: 8 words, CLK_DIV=1, base wraps, random latency
    logic        rst_bc, start_b, req_b, valid_b, sck_b, cs_b, sdo_b, busy_b, done_b, fe_b;
    logic [9:0]  addr_b;
    logic [31:0] rdata_b, wcnt_b;

    pulpino_spi_boot_loader #(.NUM_WORDS(8), .ROM_AW(10), .BASE_ADDR(32'hFFFF_FFFC), .CLK_DIV(1),
                              .CS_GAP(4), .CMD_WRITE(8'h02)) dut_b (
        .clk(clk), .rst(rst_bc), .start_i(start_b), .rom_req_o(req_b), .rom_addr_o(addr_b),
        .rom_valid_i(valid_b), .rom_rdata_i(rdata_b), .spi_clk_o(sck_b), .spi_cs_o(cs_b),
        .spi_sdo_o(sdo_b), .busy_o(busy_b), .done_o(done_b), .fetch_enable_o(fe_b),
        .word_cnt_o(wcnt_b));

    // ---------------- DUT C: 0 words
    logic        start_c, req_c, sck_c, cs_c, sdo_c, busy_c, done_c, fe_c;
    logic [9:0]  addr_c;
    logic [31:0] wcnt_c;

    pulpino_spi_boot_loader #(.NUM_WORDS(0), .ROM_AW(10), .BASE_ADDR(32'h0), .CLK_DIV(4),
                              .CS_GAP(4), .CMD_WRITE(8'h02)) dut_c (
        .clk(clk), .rst(rst_bc), .start_i(start_c), .rom_req_o(req_c), .rom_addr_o(addr_c),
        .rom_valid_i(1'b0), .rom_rdata_i(32'h0), .spi_clk_o(sck_c), .spi_cs_o(cs_c),
        .spi_sdo_o(sdo_c), .busy_o(busy_c), .done_o(done_c), .fetch_enable_o(fe_c),
        .word_cnt_o(wcnt_c));

    // ---------------- ROM B responder: random latency 0..7, spurious valids when idle
    logic [31:0] rom_b [8] = '{32'hCAFEBABE, 32'h00000001, 32'h80000000, 32'hFFFFFFFF,
                               32'h5A5A5A5A, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hF0F0F0F0};
    int   req_err = 0;
    int   lat = 0;
    logic req_prev = 1'b0, vld_prev = 1'b0;
    logic [9:0] addr_prev = '0;
    initial begin valid_b = 1'b0; rdata_b = 32'h0; end
    always @(negedge clk) begin
        if (req_b && req_prev && addr_b != addr_prev) req_err++;
        if (!req_b && req_prev && !vld_prev) req_err++;
        if (req_b) begin
            if (!req_prev) lat = int'($urandom_range(0, 7));
            if (lat == 0) begin
                valid_b = 1'b1;
                rdata_b = rom_b[addr_b[2:0]];
            end else begin
                lat--;
                valid_b = 1'b0;
                rdata_b = 32'hBAD0BAD0;
            end
        end else begin
            valid_b = ($urandom_range(0, 2) == 0);
            rdata_b = $urandom;
        end
        req_prev  = req_b;
        vld_prev  = valid_b;
        addr_prev = addr_b;
    end

    // ---------------- SPI monitors for A (k=0) and B (k=1)
    logic        m_sck [2], m_cs [2], m_sdo [2];
    assign m_sck[0] = sck_a; assign m_cs[0] = cs_a; assign m_sdo[0] = sdo_a;
    assign m_sck[1] = sck_b; assign m_cs[1] = cs_b; assign m_sdo[1] = sdo_b;

    logic [71:0] frames [2][16];
    int          fbits [2][16];
    int          fall_cyc [2][16];
    int          fcnt [2] = '{0, 0};
    int          bits [2] = '{0, 0};
    int          rise_cyc [2] = '{0, 0};
    int          gap_min [2] = '{100000, 100000};
    logic [71:0] sh [2];
    logic        sck_p [2] = '{1'b0, 1'b0};
    logic        cs_p [2] = '{1'b1, 1'b1};
    logic        sdo_p [2] = '{1'b0, 1'b0};
    int          spi_err = 0;
    int          cyc = 0;
    logic        c_activity = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!cs_c || req_c || sck_c) c_activity = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (m_sck[k] && m_cs[k]) spi_err++;
            if (m_sck[k] && sck_p[k] && m_sdo[k] != sdo_p[k]) spi_err++;
            if (!m_cs[k] && m_sck[k] && !sck_p[k]) begin
                sh[k] = {sh[k][70:0], m_sdo[k]};
                bits[k]++;
            end
            if (!m_cs[k] && cs_p[k] && fcnt[k] < 16) begin
                fall_cyc[k][fcnt[k]] = cyc;
                if (fcnt[k] > 0 && cyc - rise_cyc[k] < gap_min[k]) gap_min[k] = cyc - rise_cyc[k];
            end
            if (m_cs[k] && !cs_p[k] && fcnt[k] < 16) begin
                frames[k][fcnt[k]] = sh[k];
                fbits[k][fcnt[k]]  = bits[k];
                fcnt[k]++;
                bits[k]     = 0;
                rise_cyc[k] = cyc;
            end
            sck_p[k] = m_sck[k];
            cs_p[k]  = m_cs[k];
            sdo_p[k] = m_sdo[k];
        end
    end

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        int          d;
        int          i;
        logic [71:0] exp;
    } vec_t;
    vec_t tbl [10];

    int n;
    int base_a;

    initial begin
        tbl[0] = '{0, 0, {8'h02, 32'h00000000, 32'hDEADBEEF}};
        tbl[1] = '{0, 1, {8'h02, 32'h00000004, 32'h12345678}};
        tbl[2] = '{1, 0, {8'h02, 32'hFFFFFFFC, 32'hCAFEBABE}};
        tbl[3] = '{1, 1, {8'h02, 32'h00000000, 32'h00000001}};
        tbl[4] = '{1, 2, {8'h02, 32'h00000004, 32'h80000000}};
        tbl[5] = '{1, 3, {8'h02, 32'h00000008, 32'hFFFFFFFF}};
        tbl[6] = '{1, 4, {8'h02, 32'h0000000C, 32'h5A5A5A5A}};
        tbl[7] = '{1, 5, {8'h02, 32'h00000010, 32'hA5A5A5A5}};
        tbl[8] = '{1, 6, {8'h02, 32'h00000014, 32'h0F0F0F0F}};
        tbl[9] = '{1, 7, {8'h02, 32'h00000018, 32'hF0F0F0F0}};

        rst_a = 1'b1; rst_bc = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs",    72'(cs_a), 72'd1);
        chk("rst_sck",   72'(sck_a), 72'd0);
        chk("rst_sdo",   72'(sdo_a), 72'd0);
        chk("rst_req",   72'(req_a), 72'd0);
        chk("rst_flags", 72'({busy_a, done_a, fe_a}), 72'd0);
        chk("rst_wcnt",  72'(wcnt_a), 72'd0);
        rst_a = 1'b0; rst_bc = 1'b0;
        @(negedge clk);

        // Start all three together
        start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        chk("busy_after_start", 72'({busy_a, busy_b}), 72'b11);
        @(negedge clk);
        chk("zero_done", 72'({done_c, fe_c, busy_c}), 72'b110);

        // Repeated start mid-load must be ignored
        repeat (100) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;

        n = 0;
        while (!(done_a && done_b) && n < 5000) begin @(negedge clk); n++; end
        chk("load_timeout", 72'(n < 5000), 72'd1);
        repeat (3) @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            chk($sformatf("frame_d%0d_w%0d", tbl[v].d, tbl[v].i), frames[tbl[v].d][tbl[v].i], tbl[v].exp);
            chk($sformatf("edges_d%0d_w%0d", tbl[v].d, tbl[v].i), 72'(fbits[tbl[v].d][tbl[v].i]), 72'd72);
        end
        chk("frames_a", 72'(fcnt[0]), 72'd2);
        chk("frames_b", 72'(fcnt[1]), 72'd8);
        chk("end_a", 72'({busy_a, done_a, fe_a}), 72'b011);
        chk("end_b", 72'({busy_b, done_b, fe_b}), 72'b011);
        chk("wcnt_a", 72'(wcnt_a), 72'd2);
        chk("wcnt_b", 72'(wcnt_b), 72'd8);
        // zero-wait ROM: 2 + 144*CLK_DIV + CS_GAP = 294 cycles per word
        chk("word_period_a", 72'(fall_cyc[0][1] - fall_cyc[0][0]), 72'd294);
        chk("cs_gap_a", 72'(gap_min[0] >= 4), 72'd1);
        chk("cs_gap_b", 72'(gap_min[1] >= 4), 72'd1);
        chk("rom_handshake_b", 72'(req_err), 72'd0);

        // Start after DONE must be ignored
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (700) @(negedge clk);
        chk("post_done_frames", 72'(fcnt[0]), 72'd2);
        chk("post_done_state", 72'({busy_a, done_a, fe_a, wcnt_a}), {3'b011, 32'd2});

        // Reset during SHIFT of word 1, then reload from word 0
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        chk("rst_clears_done", 72'({done_a, fe_a, wcnt_a}), 72'd0);
        base_a = fcnt[0];
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (!(fcnt[0] == base_a + 1 && !cs_a) && n < 2000) begin @(negedge clk); n++; end
        chk("word1_timeout", 72'(n < 2000), 72'd1);
        repeat (40) @(negedge clk);
        #1 rst_a = 1'b1;
        #1;
        chk("async_rst", 72'({cs_a, sck_a, busy_a}), 72'b100);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (2) @(negedge clk);
        chk("reload_word0", frames[0][base_a], tbl[0].exp);
        chk("partial_frame", 72'(fbits[0][base_a + 1] < 72), 72'd1);
        base_a = fcnt[0];
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (!done_a && n < 2000) begin @(negedge clk); n++; end
        chk("reload_timeout", 72'(n < 2000), 72'd1);
        repeat (3) @(negedge clk);
        for (int v = 0; v < 2; v++)
            chk($sformatf("reload_w%0d", v), frames[0][base_a + v], tbl[v].exp);
        chk("reload_frames", 72'(fcnt[0] - base_a), 72'd2);
        chk("reload_wcnt", 72'(wcnt_a), 72'd2);

        chk("spi_protocol", 72'(spi_err), 72'd0);
        chk("zero_no_activity", 72'(c_activity), 72'd0);
        chk("zero_wcnt", 72'(wcnt_c), 72'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
